// File: rtl/instr_mem_loader_ctrl_if.sv
// instr_mem_loader_ctrl_if: receiver byte stream in, instruction-memory byte write bus out
interface instr_mem_loader_ctrl_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic instr_wr_en;
    logic [31:0] instr_wr_addr;
    logic [7:0] instr_wr_data;
    modport master (input rx_data, rx_valid, output rx_ready, instr_wr_en, instr_wr_addr, instr_wr_data);
    modport slave (output rx_data, rx_valid, input rx_ready, instr_wr_en, instr_wr_addr, instr_wr_data);
endinterface

// File: rtl/instr_mem_loader_ctrl.sv
// instr_mem_loader_ctrl: boot loader writing a framed byte stream into instruction memory; LOADER_CHECKSUM_EN adds a trailing checksum byte
module instr_mem_loader_ctrl #(
    parameter int INSTR_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input logic clk,
    input logic rst_n,
    instr_mem_loader_ctrl_if.master bus,
    input logic reload_req,
    output logic imem_op,
    output logic cpu_hold,
    output logic load_done,
    output logic load_err,
    output logic [15:0] bytes_loaded
);
    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK = 3'd4;
    localparam logic [2:0] S_END = S_CHK;
`else
    localparam logic [2:0] S_END = S_DONE;
`endif
    localparam logic [31:0] MAX_N = 32'(INSTR_SIZE) * 32'd4;
    logic [2:0] state;
    logic [7:0] len_lo;
    logic [15:0] len;
    logic [15:0] n;
    logic acc;
    logic fin;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif
    assign fin = (state == S_DONE) || (state == S_ERROR);
    assign bus.rx_ready = !fin;
    assign acc = bus.rx_valid && bus.rx_ready;
    assign n = {bus.rx_data, len_lo};
    assign imem_op = state == S_DONE;
    assign load_done = state == S_DONE;
    assign cpu_hold = state != S_DONE;
    assign load_err = state == S_ERROR;
    // Frame parser: one byte per handshake, one write strobe per payload byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_SYNC;
            len_lo <= '0;
            len <= '0;
            bytes_loaded <= '0;
            bus.instr_wr_en <= 1'b0;
            bus.instr_wr_addr <= '0;
            bus.instr_wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum <= '0;
`endif
        end else begin
            bus.instr_wr_en <= 1'b0;
            case (state)
                S_SYNC: if (acc && bus.rx_data == SYNC_BYTE) state <= S_LEN0;
                S_LEN0: if (acc) begin
                    len_lo <= bus.rx_data;
                    state <= S_LEN1;
                end
                S_LEN1: if (acc) begin
                    len <= n;
                    state <= {16'd0, n} > MAX_N ? S_ERROR : n == 16'd0 ? S_END : S_DATA;
                end
                S_DATA: if (acc) begin
                    bus.instr_wr_en <= 1'b1;
                    bus.instr_wr_addr <= BASE_ADDR + {16'd0, bytes_loaded};
                    bus.instr_wr_data <= bus.rx_data;
                    bytes_loaded <= bytes_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum <= sum + bus.rx_data;
`endif
                    if (bytes_loaded == len - 16'd1) state <= S_END;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: if (acc) state <= bus.rx_data == sum ? S_DONE : S_ERROR;
`endif
                default: if (reload_req || !fin) begin
                    state <= S_SYNC;
                    bytes_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                    sum <= '0;
`endif
                end
            endcase
        end
    end
endmodule
